// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one memory port between fetch (imem) and LSU (dmem),
//                    one outstanding transaction, response routed to its owner.
// Optional: ARB_ROUND_ROBIN_EN selects round-robin conflicts (else dmem wins).
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    imem_req,
  input  logic [ADDR_WIDTH-1:0]   imem_addr,
  output logic                    imem_gnt,
  output logic                    imem_rvalid,
  input  logic                    dmem_req,
  input  logic                    dmem_we,
  input  logic [DATA_WIDTH/8-1:0] dmem_be,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr,
  input  logic [DATA_WIDTH-1:0]   dmem_wdata,
  output logic                    dmem_gnt,
  output logic                    dmem_rvalid,
  output logic [DATA_WIDTH-1:0]   mem_rdata_o,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    sel
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2
  } state_e;

  state_e state_q;
  logic   sel_q;
  logic   owner_d;
  logic   in_req;
  logic   in_wait;

`ifdef ARB_ROUND_ROBIN_EN
  logic   last_owner_q;

  always_comb begin
    owner_d = dmem_req;
    if (imem_req && dmem_req) begin
      owner_d = ~last_owner_q;
    end
  end
`else
  // A lone requester wins; on conflict dmem_req is high, so dmem wins.
  assign owner_d = dmem_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (imem_req || dmem_req) begin
            sel_q   <= owner_d;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            state_q <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (mem_rvalid) begin
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= sel_q;
`endif
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_req  = (state_q == ST_REQ);
  assign in_wait = (state_q == ST_WAIT_RSP);

  // Shared path is driven only while a request is presented; zero otherwise.
  assign mem_req     = in_req;
  assign mem_addr    = !in_req ? '0 : (sel_q ? dmem_addr : imem_addr);
  assign mem_we      = in_req & sel_q & dmem_we;
  assign mem_be      = !in_req ? '0 : (sel_q ? dmem_be : '1);
  assign mem_wdata   = (in_req && sel_q) ? dmem_wdata : '0;

  assign imem_gnt    = in_req & ~sel_q & mem_gnt;
  assign dmem_gnt    = in_req &  sel_q & mem_gnt;
  assign imem_rvalid = in_wait & ~sel_q & mem_rvalid;
  assign dmem_rvalid = in_wait &  sel_q & mem_rvalid;

  assign mem_rdata_o = mem_rdata;
  assign sel         = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : directed + randomized transactions against a
//                       transaction-level model of the arbiter.
// Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] mem_rdata_o;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        sel;

  int n_chk = 0;
  int n_err = 0;

  // Requester model: index 0 = imem, 1 = dmem.
  bit          pend [2];
  logic [31:0] a_r  [2];
  logic        we_r;
  logic [3:0]  be_r;
  logic [31:0] wd_r;
  bit          last_own;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .mem_rdata_o(mem_rdata_o), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .sel(sel)
  );

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [31:0] a, input logic we,
                         input logic [3:0] be, input logic [31:0] wd);
    pend[idx] = 1'b1;
    a_r[idx]  = a;
    if (idx == 1) begin
      we_r = we;
      be_r = be;
      wd_r = wd;
    end
  endtask

  task automatic drive_reqs();
    imem_req   = pend[0];
    imem_addr  = a_r[0];
    dmem_req   = pend[1];
    dmem_addr  = a_r[1];
    dmem_we    = we_r;
    dmem_be    = be_r;
    dmem_wdata = wd_r;
  endtask

  function automatic bit exp_owner();
    if (pend[0] && pend[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
      return ~last_own;
`else
      return 1'b1;
`endif
    end
    return pend[1];
  endfunction

  task automatic idle_cycle(input bit spur, output bit own);
    @(posedge clk); #1;
    drive_reqs();
    mem_gnt    = 1'b0;
    mem_rvalid = spur;
    mem_rdata  = $urandom;
    own        = exp_owner();
    @(negedge clk);
    chk_eq("idle_mem_req", mem_req, 1'b0);
    chk_eq("idle_gnt", {imem_gnt, dmem_gnt}, 2'b00);
    chk_eq("idle_rvalid", {imem_rvalid, dmem_rvalid}, 2'b00);
    chk_eq("idle_sel_hold", sel, last_own);
  endtask

  task automatic req_cycles(input bit own, input int gdly);
    for (int i = 0; i <= gdly; i++) begin
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      mem_gnt    = (i == gdly);
      @(negedge clk);
      chk_eq("req_mem_req", mem_req, 1'b1);
      chk_eq("req_sel", sel, own);
      chk_eq("req_addr", mem_addr, a_r[own]);
      chk_eq("req_we", mem_we, own ? we_r : 1'b0);
      chk_eq("req_be", mem_be, own ? be_r : 4'hF);
      chk_eq("req_wdata", mem_wdata, own ? wd_r : 32'h0);
      chk_eq("req_imem_gnt", imem_gnt, (i == gdly) && !own);
      chk_eq("req_dmem_gnt", dmem_gnt, (i == gdly) && own);
    end
  endtask

  task automatic wait_cycles(input bit own, input int rdly, input logic [31:0] rdata);
    for (int i = 0; i <= rdly; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        mem_gnt   = 1'b0;
        pend[own] = 1'b0;
        drive_reqs();
      end
      mem_rvalid = (i == rdly);
      mem_rdata  = (i == rdly) ? rdata : $urandom;
      @(negedge clk);
      chk_eq("wait_mem_req", mem_req, 1'b0);
      chk_eq("wait_mem_we", mem_we, 1'b0);
      chk_eq("wait_gnt", {imem_gnt, dmem_gnt}, 2'b00);
      chk_eq("wait_imem_rvalid", imem_rvalid, (i == rdly) && !own);
      chk_eq("wait_dmem_rvalid", dmem_rvalid, (i == rdly) && own);
      chk_eq("rdata_pass", mem_rdata_o, mem_rdata);
    end
    last_own = own;
  endtask

  task automatic run_txn(input int gdly, input int rdly, input bit spur,
                         input logic [31:0] rdata, output bit own);
    idle_cycle(spur, own);
    req_cycles(own, gdly);
    wait_cycles(own, rdly, rdata);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_outs"},
           {mem_req, mem_we, mem_be, mem_addr, mem_wdata, imem_gnt, dmem_gnt,
            imem_rvalid, dmem_rvalid, sel}, 64'h0);
  endtask

  initial begin
    bit own;
    rst_n = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    a_r[0] = '0; a_r[1] = '0; we_r = 1'b0; be_r = '0; wd_r = '0;
    last_own = 1'b0;
    drive_reqs();
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1; rst_n = 1'b1;

    // Conflict: both requesters kept busy for four transactions.
    for (int t = 0; t < 4; t++) begin
      if (!pend[0]) set_req(0, 32'h1000 + 32'(t * 4), 1'b0, 4'h0, 32'h0);
      if (!pend[1]) set_req(1, 32'h8000 + 32'(t * 4), 1'(t), 4'(t + 1), $urandom);
      run_txn(0, 0, 1'b0, $urandom, own);
    end
    while (pend[0] || pend[1]) run_txn(1, 1, 1'b0, $urandom, own);

    // Single fetch and single store.
    set_req(0, 32'h100, 1'b0, 4'h0, 32'h0);
    run_txn(1, 1, 1'b0, 32'h0000_0013, own);
    set_req(1, 32'h2000, 1'b1, 4'h3, 32'hDEAD_BEEF);
    run_txn(0, 0, 1'b0, $urandom, own);

    // Stalled memory: five cycles without mem_gnt.
    set_req(1, 32'h2040, 1'b0, 4'hF, 32'h0);
    run_txn(5, 2, 1'b0, $urandom, own);

    // Reset while waiting for the response, with the response arriving meanwhile.
    set_req(1, 32'h3000, 1'b1, 4'hC, 32'h1234_5678);
    idle_cycle(1'b0, own);
    req_cycles(own, 0);
    @(posedge clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    pend[1] = 1'b0; drive_reqs();
    @(negedge clk);
    chk_eq("pre_reset_sel", sel, 1'b1);
    #2; rst_n = 1'b0; mem_rvalid = 1'b1;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1; last_own = 1'b0;
    @(negedge clk);
    chk_eq("stray_rvalid", {imem_rvalid, dmem_rvalid, mem_req}, 3'b000);
    @(posedge clk); #1; mem_rvalid = 1'b0;
    @(negedge clk);
    chk_eq("stray_state", mem_req, 1'b0);
    set_req(0, 32'h400, 1'b0, 4'h0, 32'h0);
    run_txn(0, 1, 1'b0, $urandom, own);

    // Spurious response while idle.
    @(posedge clk); #1; mem_rvalid = 1'b1;
    @(negedge clk);
    chk_eq("spur_rvalid", {imem_rvalid, dmem_rvalid}, 2'b00);
    @(posedge clk); #1; mem_rvalid = 1'b0;
    @(negedge clk);
    chk_eq("spur_state", mem_req, 1'b0);
    chk_eq("spur_sel", sel, last_own);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      if (!pend[0] && $urandom_range(1, 0) == 1)
        set_req(0, $urandom, 1'b0, 4'h0, 32'h0);
      if (!pend[1] && $urandom_range(1, 0) == 1)
        set_req(1, $urandom, 1'($urandom), 4'($urandom), $urandom);
      if (!pend[0] && !pend[1])
        set_req(int'($urandom_range(1, 0)), $urandom, 1'($urandom), 4'($urandom), $urandom);
      run_txn(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
              $urandom_range(3, 0) == 0, $urandom, own);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
